// File: rtl/frame_proc_pkg.sv
// Shared types and limits for the frame-difference motion statistics block.
// Holds the diff_mode encodings, the frame-state enum and the legal parameter bounds.
package frame_proc_pkg;

  typedef enum logic [1:0] {
    MODE_ABS = 2'b00,
    MODE_POS = 2'b01,
    MODE_NEG = 2'b10,
    MODE_OFF = 2'b11
  } diff_mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } frame_state_e;

  localparam int DW_MIN      = 4;
  localparam int DW_MAX      = 16;
  localparam int PRE_LAT_MAX = 7;
  localparam int CNT_W_MIN   = 8;
  localparam int CNT_W_MAX   = 24;

endpackage

// File: rtl/frame_diff_stat_if.sv
// Video stream bundle: incoming current/previous luma with sync, outgoing motion bit with sync.
// No backpressure: the stream is paced purely by the clken qualifier.
interface frame_diff_stat_if #(
  parameter int DW = 8
);
  logic          per_frame_vsync;
  logic          per_frame_href;
  logic          per_frame_clken;
  logic [DW-1:0] per_img_Y;
  logic [DW-1:0] pre_img_Y;
  logic          post_frame_vsync;
  logic          post_frame_href;
  logic          post_frame_clken;
  logic          post_img_bit;

  modport master (
    output per_frame_vsync, per_frame_href, per_frame_clken, per_img_Y, pre_img_Y,
    input  post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit
  );

  modport slave (
    input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_Y, pre_img_Y,
    output post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit
  );
endinterface

// File: rtl/sync_delay_line.sv
// Fixed-depth register delay line; DEPTH=0 degenerates to a wire.
// Latency DEPTH cycles, no backpressure (free-running shift every clock).
module sync_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = sys_clk ^ sys_rst_n;
    assign dout = din;
  end else begin : g_dly
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/frame_diff_stat.sv
// Per-pixel frame-difference motion detection plus a saturating per-frame motion count.
// Latency PRE_LAT+1 cycles from per_* to post_*; no backpressure, stream paced by clken.
module frame_diff_stat
  import frame_proc_pkg::*;
#(
  parameter int DW      = 8,
  parameter int PRE_LAT = 1,
  parameter int CNT_W   = 20
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  frame_diff_stat_if.slave vid,
  input  logic [DW-1:0]    diff_threshold,
  input  logic [1:0]       diff_mode,
  output logic [CNT_W-1:0] motion_cnt,
  output logic             motion_cnt_valid
);

  localparam logic [CNT_W-1:0] ACC_MAX = '1;

  logic [DW-1:0] cur_y;
  logic [2:0]    sync_al;
  logic          al_vs, al_hr, al_ce;

  sync_delay_line #(.WIDTH(DW), .DEPTH(PRE_LAT)) u_dly_data (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .din       (vid.per_img_Y),
    .dout      (cur_y)
  );

  sync_delay_line #(.WIDTH(3), .DEPTH(PRE_LAT)) u_dly_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .din       ({vid.per_frame_vsync, vid.per_frame_href, vid.per_frame_clken}),
    .dout      (sync_al)
  );

  assign {al_vs, al_hr, al_ce} = sync_al;

  logic          al_vs_d;
  logic [DW-1:0] thr_sh;
  diff_mode_e    mode_sh;
  logic          bit_r;
  logic          post_vs, post_hr, post_ce;
  logic [DW:0]   cur_x, pre_x, thr_x, d_pos, d_neg;
  logic          hit;

  assign cur_x = {1'b0, cur_y};
  assign pre_x = {1'b0, vid.pre_img_Y};
  assign thr_x = {1'b0, thr_sh};

  // One-sided differences clamp at zero, so no wrap can fake a large delta.
  always_comb begin
    d_pos = '0;
    d_neg = '0;
    hit   = 1'b0;
    if (cur_x > pre_x) d_pos = cur_x - pre_x;
    if (pre_x > cur_x) d_neg = pre_x - cur_x;
    case (mode_sh)
      MODE_ABS: hit = (d_pos > thr_x) | (d_neg > thr_x);
      MODE_POS: hit = d_pos > thr_x;
      MODE_NEG: hit = d_neg > thr_x;
      default:  hit = 1'b0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      al_vs_d <= 1'b0;
      thr_sh  <= '0;
      mode_sh <= MODE_ABS;
      bit_r   <= 1'b0;
      post_vs <= 1'b0;
      post_hr <= 1'b0;
      post_ce <= 1'b0;
    end else begin
      al_vs_d <= al_vs;
      if (al_vs && !al_vs_d) begin
        thr_sh  <= diff_threshold;
        mode_sh <= diff_mode_e'(diff_mode);
      end
      if (al_ce) bit_r <= hit;
      post_vs <= al_vs;
      post_hr <= al_hr;
      post_ce <= al_ce;
    end
  end

  logic pix_bit;
  assign pix_bit              = bit_r & post_hr & post_ce;
  assign vid.post_img_bit     = pix_bit;
  assign vid.post_frame_vsync = post_vs;
  assign vid.post_frame_href  = post_hr;
  assign vid.post_frame_clken = post_ce;

  frame_state_e     state;
  logic             post_vs_d;
  logic [CNT_W-1:0] acc;

  // A hit on the vsync edge belongs to the new frame, hence the load of pix_bit.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state            <= ST_IDLE;
      post_vs_d        <= 1'b0;
      acc              <= '0;
      motion_cnt       <= '0;
      motion_cnt_valid <= 1'b0;
    end else begin
      post_vs_d        <= post_vs;
      motion_cnt_valid <= 1'b0;
      if (post_vs && !post_vs_d) begin
        acc <= {{(CNT_W-1){1'b0}}, pix_bit};
        case (state)
          ST_IDLE:   state <= ST_ACTIVE;
          ST_ACTIVE: begin
            motion_cnt       <= acc;
            motion_cnt_valid <= 1'b1;
          end
        endcase
      end else if (pix_bit && acc != ACC_MAX) begin
        acc <= acc + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_frame_diff_stat.sv
// Directed bench: two instances (PRE_LAT=1/CNT_W=20 and PRE_LAT=3/CNT_W=8) share one stimulus stream.
// Previous-frame luma is fed to each instance delayed by its own PRE_LAT.
module tb_frame_diff_stat;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        vs = 1'b0, hr = 1'b0, ce = 1'b0;
  logic [7:0]  cur = '0, prv = '0;
  logic [7:0]  diff_threshold = 8'd20;
  logic [1:0]  diff_mode = 2'b00;
  logic [7:0]  h [3];
  logic [19:0] motion_cnt_a;
  logic [7:0]  motion_cnt_b;
  logic        motion_cnt_valid_a, motion_cnt_valid_b;

  int total = 0;
  int bad = 0;
  int strb_a = 0, strb_b = 0;
  logic [19:0] cap_a = '0;
  logic [7:0]  cap_b = '0;

  always #5 sys_clk = ~sys_clk;

  frame_diff_stat_if #(.DW(8)) bus_a ();
  frame_diff_stat_if #(.DW(8)) bus_b ();

  assign bus_a.per_frame_vsync = vs;
  assign bus_a.per_frame_href  = hr;
  assign bus_a.per_frame_clken = ce;
  assign bus_a.per_img_Y       = cur;
  assign bus_a.pre_img_Y       = h[0];
  assign bus_b.per_frame_vsync = vs;
  assign bus_b.per_frame_href  = hr;
  assign bus_b.per_frame_clken = ce;
  assign bus_b.per_img_Y       = cur;
  assign bus_b.pre_img_Y       = h[2];

  frame_diff_stat #(.DW(8), .PRE_LAT(1), .CNT_W(20)) u_a (
    .sys_clk          (sys_clk),
    .sys_rst_n        (sys_rst_n),
    .vid              (bus_a),
    .diff_threshold   (diff_threshold),
    .diff_mode        (diff_mode),
    .motion_cnt       (motion_cnt_a),
    .motion_cnt_valid (motion_cnt_valid_a)
  );

  frame_diff_stat #(.DW(8), .PRE_LAT(3), .CNT_W(8)) u_b (
    .sys_clk          (sys_clk),
    .sys_rst_n        (sys_rst_n),
    .vid              (bus_b),
    .diff_threshold   (diff_threshold),
    .diff_mode        (diff_mode),
    .motion_cnt       (motion_cnt_b),
    .motion_cnt_valid (motion_cnt_valid_b)
  );

  // Frame-buffer model: pre pixel lags its matching current pixel.
  always @(posedge sys_clk) begin
    h[0] <= prv;
    h[1] <= h[0];
    h[2] <= h[1];
  end

  always @(negedge sys_clk) begin
    if (motion_cnt_valid_a) begin
      strb_a <= strb_a + 1;
      cap_a  <= motion_cnt_a;
    end
    if (motion_cnt_valid_b) begin
      strb_b <= strb_b + 1;
      cap_b  <= motion_cnt_b;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic vsync_pulse();
    @(negedge sys_clk);
    hr = 1'b0; ce = 1'b0; vs = 1'b1;
    @(negedge sys_clk);
    @(negedge sys_clk);
    vs = 1'b0;
    repeat (8) @(negedge sys_clk);
  endtask

  task automatic set_cfg(input logic [7:0] thr, input logic [1:0] mode);
    diff_threshold = thr;
    diff_mode = mode;
    vsync_pulse();
  endtask

  // Pixels with index < n_motion differ by 50, the rest are identical.
  task automatic run_frame(input int lines, input int n_motion, input int chg_line, input logic [7:0] chg_thr);
    for (int ln = 0; ln < lines; ln++) begin
      if (ln == chg_line) diff_threshold = chg_thr;
      for (int p = 0; p < 16; p++) begin
        @(negedge sys_clk);
        hr = 1'b1; ce = 1'b1;
        cur = ((ln * 16 + p) < n_motion) ? 8'd150 : 8'd100;
        prv = 8'd100;
      end
      @(negedge sys_clk);
      hr = 1'b0; ce = 1'b0;
      @(negedge sys_clk);
    end
    repeat (6) @(negedge sys_clk);
  endtask

  task automatic px(input string tag, input logic [7:0] c, input logic [7:0] p, input logic h_en, input logic e);
    @(negedge sys_clk);
    vs = 1'b0; hr = h_en; ce = 1'b1; cur = c; prv = p;
    for (int k = 1; k <= 4; k++) begin
      @(negedge sys_clk);
      if (k == 1) begin hr = 1'b0; ce = 1'b0; cur = '0; prv = '0; end
      if (k == 2) chk({tag, "_a"}, bus_a.post_img_bit, e);
      if (k == 4) chk({tag, "_b"}, bus_b.post_img_bit, e);
    end
  endtask

  initial begin
    int s0;
    repeat (3) @(negedge sys_clk);
    chk("rst_bit_a", bus_a.post_img_bit, 0);
    chk("rst_vs_b", bus_b.post_frame_vsync, 0);
    chk("rst_cnt_a", motion_cnt_a, 0);
    chk("rst_vld_b", motion_cnt_valid_b, 0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    vsync_pulse();
    chk("first_vs_strb_a", strb_a, 0);
    chk("first_vs_strb_b", strb_b, 0);
    run_frame(4, 7, -1, 8'd0);
    vsync_pulse();
    chk("f7_strb_a", strb_a, 1);
    chk("f7_cnt_a", cap_a, 7);
    chk("f7_cnt_b", cap_b, 7);
    run_frame(4, 0, -1, 8'd0);
    vsync_pulse();
    chk("f0_strb_b", strb_b, 2);
    chk("f0_cnt_a", cap_a, 0);
    chk("f0_cnt_b", cap_b, 0);
    run_frame(4, 64, -1, 8'd0);
    vsync_pulse();
    chk("f64_strb_a", strb_a, 3);
    chk("f64_cnt_a", cap_a, 64);
    chk("f64_cnt_b", cap_b, 64);

    run_frame(20, 300, 5, 8'd100);
    vsync_pulse();
    chk("sat_cnt_a", cap_a, 300);
    chk("sat_cnt_b", cap_b, 255);
    run_frame(4, 64, -1, 8'd0);
    vsync_pulse();
    chk("thr_next_strb_b", strb_b, 5);
    chk("thr_next_cnt_a", cap_a, 0);
    chk("thr_next_cnt_b", cap_b, 0);

    set_cfg(8'd20, 2'b00);
    px("abs_neg21", 8'd100, 8'd121, 1'b1, 1'b1);
    px("abs_eq20", 8'd100, 8'd120, 1'b1, 1'b0);
    px("abs_pos50", 8'd200, 8'd150, 1'b1, 1'b1);
    px("href0", 8'd200, 8'd50, 1'b0, 1'b0);
    set_cfg(8'd10, 2'b01);
    px("pos_dark", 8'd50, 8'd80, 1'b1, 1'b0);
    px("pos_bright", 8'd80, 8'd50, 1'b1, 1'b1);
    px("pos_eq10", 8'd80, 8'd70, 1'b1, 1'b0);
    set_cfg(8'd10, 2'b10);
    px("neg_dark", 8'd50, 8'd80, 1'b1, 1'b1);
    px("neg_bright", 8'd80, 8'd50, 1'b1, 1'b0);
    set_cfg(8'd10, 2'b11);
    px("off_dark", 8'd50, 8'd80, 1'b1, 1'b0);
    px("off_bright", 8'd80, 8'd50, 1'b1, 1'b0);

    @(negedge sys_clk);
    vs = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge sys_clk);
      if (k == 1) vs = 1'b0;
      chk($sformatf("vs_dly_a_%0d", k), bus_a.post_frame_vsync, (k == 2));
      chk($sformatf("vs_dly_b_%0d", k), bus_b.post_frame_vsync, (k == 4));
    end
    repeat (4) @(negedge sys_clk);

    set_cfg(8'd20, 2'b00);
    run_frame(4, 5, -1, 8'd0);
    s0 = strb_a;
    vsync_pulse();
    chk("pre_rst_strb_a", strb_a, s0 + 1);
    chk("pre_rst_cnt_b", cap_b, 5);
    for (int p = 0; p < 10; p++) begin
      @(negedge sys_clk);
      hr = 1'b1; ce = 1'b1; cur = 8'd150; prv = 8'd100;
    end
    @(negedge sys_clk);
    chk("mid_bit_a", bus_a.post_img_bit, 1);
    sys_rst_n = 1'b0;
    hr = 1'b0; ce = 1'b0; cur = '0; prv = '0;
    #1;
    chk("mrst_bit_a", bus_a.post_img_bit, 0);
    chk("mrst_bit_b", bus_b.post_img_bit, 0);
    chk("mrst_href_a", bus_a.post_frame_href, 0);
    chk("mrst_clken_b", bus_b.post_frame_clken, 0);
    chk("mrst_cnt_a", motion_cnt_a, 0);
    chk("mrst_cnt_b", motion_cnt_b, 0);
    chk("mrst_vld_a", motion_cnt_valid_a, 0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    s0 = strb_a;
    vsync_pulse();
    chk("post_rst_nostrb_a", strb_a, s0);
    run_frame(4, 9, -1, 8'd0);
    vsync_pulse();
    chk("post_rst_strb_a", strb_a, s0 + 1);
    chk("post_rst_cnt_a", cap_a, 9);
    chk("post_rst_cnt_b", cap_b, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_diff_stat.md
FRAME_DIFF_STAT -- requirements
Module: frame_diff_stat

Interface
REQ-001 Parameter DW, default 8: pixel luma width, legal 4..16.
REQ-002 Parameter PRE_LAT, default 1: cycles by which pre_img_Y lags per_img_Y, legal 0..7.
REQ-003 Parameter CNT_W, default 20: motion counter width, legal 8..24.
REQ-004 sys_clk  in  1  system clock; all logic on rising edge.
REQ-005 sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 per_frame_vsync / per_frame_href / per_frame_clken  in  1 each  input sync; vsync active-high, frame starts on its rising edge.
REQ-007 per_img_Y  in  DW  current-frame luma.
REQ-008 pre_img_Y  in  DW  previous-frame luma from frame buffer, PRE_LAT cycles behind per_img_Y.
REQ-009 diff_threshold  in  DW  difference threshold, quasi-static.
REQ-010 diff_mode  in  2  00 absolute, 01 brighten only, 10 darken only, 11 disable.
REQ-011 post_frame_vsync / post_frame_href / post_frame_clken  out  1 each  delayed sync.
REQ-012 post_img_bit  out  1  motion bit.
REQ-013 motion_cnt  out  CNT_W  motion-pixel count of last complete frame.
REQ-014 motion_cnt_valid  out  1  one-cycle strobe when motion_cnt updates.

Function
REQ-015 per_img_Y and the three sync inputs SHALL pass through a PRE_LAT-deep delay line (PRE_LAT=0: wire) so delayed current pixel aligns with pre_img_Y.
REQ-016 Compare stage SHALL register one result per aligned pixel when aligned clken=1; otherwise it holds its value.
REQ-017 Outputs post_frame_* SHALL equal per_frame_* delayed exactly PRE_LAT+1 cycles.
REQ-018 Difference arithmetic SHALL be unsigned, DW+1 bits, no wrap: d_pos = cur-pre if cur>pre else 0; d_neg = pre-cur if pre>cur else 0.
REQ-019 Mode 00: bit = (d_pos > thr) or (d_neg > thr); 01: d_pos > thr; 10: d_neg > thr; 11: bit = 0.
REQ-020 Comparison SHALL be strict greater-than; difference equal to threshold gives 0.
REQ-021 diff_threshold and diff_mode SHALL be captured into shadow registers on the rising edge of the aligned vsync; changes mid-frame take effect next frame.
REQ-022 post_img_bit SHALL be registered bit ANDed with post_frame_href and post_frame_clken.
REQ-023 Accumulator SHALL increment by 1 each cycle post_img_bit=1, saturating at 2^CNT_W-1.
REQ-024 On rising edge of post_frame_vsync: if frame_seen=1, motion_cnt <= accumulator and motion_cnt_valid=1 for one cycle; accumulator cleared same cycle; frame_seen set to 1.
REQ-025 A post_img_bit=1 coincident with the vsync rising edge SHALL count into the new frame (accumulator loads 1).
REQ-026 First vsync edge after reset SHALL not strobe motion_cnt_valid (partial frame discarded).
REQ-027 Frame-state FSM: IDLE (no vsync edge seen since reset) -> ACTIVE on first post vsync rise; ACTIVE self-loops publishing at each rise; only reset returns to IDLE.

Reset
REQ-028 Reset SHALL clear delay line, compare register, shadow registers (threshold 0, mode 00), accumulator, motion_cnt, motion_cnt_valid, frame_seen; all outputs 0.
REQ-029 Reset mid-frame SHALL return FSM to IDLE; the interrupted frame is never published.

Structure
REQ-030 Shared package frame_proc_pkg SHALL hold diff_mode encodings (MODE_ABS, MODE_POS, MODE_NEG, MODE_OFF) and parameter limit constants.
REQ-031 Sub-module sync_delay_line (parameter WIDTH, DEPTH, DEPTH=0 passthrough) SHALL implement the alignment delay, reused for data and sync.

Verification
REQ-032 DW=8, PRE_LAT=1, mode 00, thr 20: cur 100/pre 121 -> bit 1; cur 100/pre 120 -> bit 0; cur 200/pre 150 -> bit 1.
REQ-033 Mode 01, thr 10: cur 50/pre 80 -> 0; cur 80/pre 50 -> 1; mode 10 same pixels -> 1 then 0; mode 11 -> 0.
REQ-034 PRE_LAT=3: sync pulses emerge exactly 4 cycles later; href=0 forces post_img_bit 0 whatever the data.
REQ-035 Three 16x4 frames with 7, 0, 64 motion pixels: no strobe at first vsync; then motion_cnt 7, 0, 64 each with one-cycle strobe.
REQ-036 CNT_W=8, frame with 300 motion pixels -> motion_cnt 255; threshold changed mid-frame affects only the next frame.
REQ-037 Assert sys_rst_n low mid-frame: all outputs 0 next edge; after release first vsync produces no strobe.
